// File: rtl/can_tx_en_gen.sv
// CAN transceiver driver-enable generator: follows the controller TX line, frames
// bursts of bus activity with tx_en, and cuts off a controller stuck dominant.
module can_tx_en_gen #(
  parameter int unsigned BIT_CYCLES   = 100,
  parameter int unsigned IDLE_BITS    = 11,
  parameter int unsigned TIMEOUT_BITS = 17,
  parameter logic [15:0] FRAME_MAX    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        can_tx_in,
  input  logic        clear_timeout,
  output logic        can_tx_out,
  output logic        tx_en,
  output logic        timeout_flag,
  output logic [15:0] frame_count
);
  localparam int unsigned IDLE_CYC = IDLE_BITS * BIT_CYCLES;
  localparam int unsigned TO_CYC   = TIMEOUT_BITS * BIT_CYCLES;
  localparam int unsigned MAX_CYC  = (IDLE_CYC > TO_CYC) ? IDLE_CYC : TO_CYC;
  localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] IDLE_THR = CNT_W'(IDLE_CYC);
  localparam logic [CNT_W-1:0] TO_THR   = CNT_W'(TO_CYC);

  typedef enum logic [1:0] {IDLE, ACTIVE, FAULT} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             can_tx_out_q, can_tx_out_d;
  logic             tx_en_q, tx_en_d;
  logic             timeout_flag_q, timeout_flag_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             tx_s, dom_to, rec_done;

  assign tx_s = sync2_q;

  always_comb begin
    dom_to   = !tx_s && (run_cnt_q >= TO_THR);
    rec_done = tx_s && (run_cnt_q >= IDLE_THR);
    // sync1 holds the level tx_s takes next cycle, so a mismatch marks a new run
    if (sync1_q != sync2_q)
      run_cnt_d = CNT_W'(1);
    else if (run_cnt_q == CNT_SAT)
      run_cnt_d = run_cnt_q;
    else
      run_cnt_d = run_cnt_q + 1'b1;

    state_d        = state_q;
    can_tx_out_d   = tx_s;
    tx_en_d        = tx_en_q;
    timeout_flag_d = timeout_flag_q;
    frame_count_d  = frame_count_q;
    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        if (!tx_s) begin
          state_d = ACTIVE;
          tx_en_d = 1'b1;
        end
      end
      ACTIVE: begin
        tx_en_d = 1'b1;
        if (dom_to) begin
          state_d        = FAULT;
          tx_en_d        = 1'b0;
          can_tx_out_d   = 1'b1;
          timeout_flag_d = 1'b1;
        end else if (rec_done) begin
          state_d = IDLE;
          tx_en_d = 1'b0;
          if (frame_count_q < FRAME_MAX)
            frame_count_d = frame_count_q + 16'd1;
        end
      end
      FAULT: begin
        tx_en_d      = 1'b0;
        can_tx_out_d = 1'b1;
        // only leave once the controller has let go of the bus
        if (clear_timeout && tx_s) begin
          state_d        = IDLE;
          timeout_flag_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      run_cnt_q      <= '0;
      can_tx_out_q   <= 1'b1;
      tx_en_q        <= 1'b0;
      timeout_flag_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= can_tx_in;
      sync2_q        <= sync1_q;
      run_cnt_q      <= run_cnt_d;
      can_tx_out_q   <= can_tx_out_d;
      tx_en_q        <= tx_en_d;
      timeout_flag_q <= timeout_flag_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign can_tx_out   = can_tx_out_q;
  assign tx_en        = tx_en_q;
  assign timeout_flag = timeout_flag_q;
  assign frame_count  = frame_count_q;
endmodule
